rf_wb_buffer: RTL

RF_WB_BUFFER -- requirements
Module: rf_wb_buffer

---
 rtl/mips_pkg.sv | 12 +
 rtl/rf_wb_fifo.sv | 63 ++++++
 rtl/rf_wb_buffer.sv | 101 ++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared register-file widths and the pending-write entry layout used by the
// write-back buffer and its storage.
package mips_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;

    typedef struct packed {
        logic                  live;
        logic [REG_ADDR_W-1:0] addr;
        logic [DATA_W-1:0]     data;
    } wb_entry_t;
endpackage

// File: rtl/rf_wb_fifo.sv
// In-order storage for pending register writes: entries, wrapping pointers,
// occupancy count and the per-entry live-bit kill.
import mips_pkg::*;

module rf_wb_fifo #(
    parameter int DEPTH = 4,
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push_i,
    input  logic [REG_ADDR_W-1:0]   push_addr_i,
    input  logic [DATA_W-1:0]       push_data_i,
    input  logic                    pop_i,
    input  logic                    kill_i,
    input  logic [REG_ADDR_W-1:0]   kill_addr_i,
    output wb_entry_t [DEPTH-1:0]   entries_o,
    output logic [PW-1:0]           rd_ptr_o,
    output logic [CW-1:0]           count_o
);
    wb_entry_t [DEPTH-1:0] mem_q, mem_d;
    logic [PW-1:0]         rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0]         cnt_q, cnt_d;

    always_comb begin
        mem_d = mem_q;
        // Kill first so a same-cycle push to the killed address stays live.
        for (int i = 0; i < DEPTH; i++) begin
            if (kill_i && (mem_q[i].addr == kill_addr_i)) begin
                mem_d[i].live = 1'b0;
            end
        end
        if (push_i) begin
            mem_d[wr_q] = '{live: 1'b1, addr: push_addr_i, data: push_data_i};
        end
        wr_d = push_i ? wr_q + 1'b1 : wr_q;
        rd_d = pop_i  ? rd_q + 1'b1 : rd_q;
        case ({push_i, pop_i})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '0;
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    assign entries_o = mem_q;
    assign rd_ptr_o  = rd_q;
    assign count_o   = cnt_q;
endmodule

// File: rtl/rf_wb_buffer.sv
// Write-back buffer: parks multicycle-unit register writes until the main
// datapath leaves the register-file write port idle, with read bypass.
import mips_pkg::*;

module rf_wb_buffer #(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [REG_ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]       req_data,
    input  logic                    cpu_we,
    input  logic [REG_ADDR_W-1:0]   cpu_wa,
    input  logic [DATA_W-1:0]       cpu_wd,
    output logic                    rf_we,
    output logic [REG_ADDR_W-1:0]   rf_wa,
    output logic [DATA_W-1:0]       rf_wd,
    input  logic [REG_ADDR_W-1:0]   ra1,
    input  logic [REG_ADDR_W-1:0]   ra2,
    output logic                    hit1,
    output logic                    hit2,
    output logic [DATA_W-1:0]       byp1,
    output logic [DATA_W-1:0]       byp2,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    empty
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    wb_entry_t [DEPTH-1:0] entries;
    wb_entry_t [DEPTH-1:0] ordered;
    logic [DEPTH-1:0]      occupied;
    logic [PW-1:0]         rd_ptr;
    logic                  push, pop, kill;

    assign req_ready = (count < DEPTH_C);
    assign empty     = (count == '0);
    assign push      = req_valid && req_ready && (req_addr != '0);
    assign pop       = !cpu_we && !empty;
    assign kill      = cpu_we && (cpu_wa != '0);

    rf_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push),
        .push_addr_i (req_addr),
        .push_data_i (req_data),
        .pop_i       (pop),
        .kill_i      (kill),
        .kill_addr_i (cpu_wa),
        .entries_o   (entries),
        .rd_ptr_o    (rd_ptr),
        .count_o     (count)
    );

    always_comb begin
        rf_we = 1'b0;
        rf_wa = '0;
        rf_wd = '0;
        if (cpu_we) begin
            rf_we = 1'b1;
            rf_wa = cpu_wa;
            rf_wd = cpu_wd;
        end else if (!empty) begin
            rf_we = entries[rd_ptr].live;
            rf_wa = entries[rd_ptr].addr;
            rf_wd = entries[rd_ptr].data;
        end
        rf_we = rf_we && rst_n;
    end

    // Oldest-first view of the ring so the last match found is the youngest.
    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            ordered[k]  = entries[rd_ptr + PW'(k)];
            occupied[k] = (CW'(k) < count);
        end
    end

    always_comb begin
        hit1 = 1'b0;
        byp1 = '0;
        hit2 = 1'b0;
        byp2 = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (occupied[k] && ordered[k].live) begin
                if ((ra1 != '0) && (ordered[k].addr == ra1)) begin
                    hit1 = 1'b1;
                    byp1 = ordered[k].data;
                end
                if ((ra2 != '0) && (ordered[k].addr == ra2)) begin
                    hit2 = 1'b1;
                    byp2 = ordered[k].data;
                end
            end
        end
    end
endmodule
